// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encoding,
// baud divisor computation and 3-sample majority vote.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DELIVER,
    BREAK_WAIT
  } rx_state_t;

  function automatic int bps_cnt(input int clk_fre, input int bps);
    return clk_fre / bps;
  endfunction

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous RX pin with falling-edge
// detect; all flops reset to the idle level so reset never fakes a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rxd,
  output logic rxd_sync,
  output logic fall
);

  logic d1, d2, d3;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d1 <= 1'b1;
      d2 <= 1'b1;
      d3 <= 1'b1;
    end else begin
      d1 <= rxd;
      d2 <= d1;
      d3 <= d2;
    end
  end

  assign rxd_sync = d2;
  assign fall     = d3 & ~d2;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with mid-bit majority voting and a one-entry
// valid/ready holding register. Optional parity bit enabled by UART_RX_PARITY_EN.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 25_000_000,
  parameter int BPS        = 9_600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_par_err,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int BPS_CNT = bps_cnt(CLK_FRE, BPS);
  localparam int HALF    = BPS_CNT >> 1;
  localparam int CNT_W   = $clog2(BPS_CNT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] SMP0     = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP1     = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP2     = CNT_W'(HALF + 1);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  if (BPS_CNT < 8) begin : g_bad_bps
    $error("uart_rx_param: CLK_FRE/BPS must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_rx_param: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
    $error("uart_rx_param: PARITY_ODD must be 0 or 1");
  end

  rx_state_t state, state_nxt;

  logic                 rxd_sync, fall;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_idx;
  logic                 s0, s1;
  logic [DATA_BITS-1:0] shreg;
  logic [7:0]           word;
  logic                 ferr_acc;
  logic                 decide, bit_end, vote, load;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (uart_rxd),
    .rxd_sync (rxd_sync),
    .fall     (fall)
  );

  assign decide  = (clk_cnt == SMP2);
  assign bit_end = (clk_cnt == CNT_LAST);
  assign vote    = vote3(s0, s1, rxd_sync);
  assign load    = (state == DELIVER) && (!rx_valid || rx_ready);

  always_comb begin
    word = '0;
    word[DATA_BITS-1:0] = shreg;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (fall) state_nxt = START;
      START: begin
        if (decide && vote) state_nxt = IDLE;
        else if (bit_end)   state_nxt = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
      PARITY:     if (bit_end) state_nxt = STOP;
      // The frame closes at the last stop-bit decision so the next start edge is never missed.
      STOP: begin
        if (decide && bit_idx == STOP_LAST)
          state_nxt = (ferr_acc || !vote) ? BREAK_WAIT : DELIVER;
      end
      DELIVER:    state_nxt = IDLE;
      BREAK_WAIT: if (rxd_sync) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      s0       <= 1'b1;
      s1       <= 1'b1;
      shreg    <= '0;
      ferr_acc <= 1'b0;
    end else begin
      if (state != state_nxt || bit_end || state == IDLE ||
          state == DELIVER || state == BREAK_WAIT)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + CNT_W'(1);

      if (state != state_nxt)
        bit_idx <= '0;
      else if (bit_end && (state == DATA || state == STOP))
        bit_idx <= bit_idx + 3'd1;

      if (clk_cnt == SMP0) s0 <= rxd_sync;
      if (clk_cnt == SMP1) s1 <= rxd_sync;

      if (state == DATA && decide)
        shreg <= {vote, shreg[DATA_BITS-1:1]};

      if (state == IDLE)
        ferr_acc <= 1'b0;
      else if (state == STOP && decide && !vote)
        ferr_acc <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= (state == STOP) && (state_nxt == BREAK_WAIT);
      rx_overrun   <= (state == DELIVER) && rx_valid && !rx_ready;
      if (load) begin
        rx_data  <= word;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_acc, hold_par;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      par_err_acc <= 1'b0;
      hold_par    <= 1'b0;
    end else begin
      if (state == PARITY && decide)
        par_err_acc <= vote ^ (^shreg) ^ PARITY_ODD[0];
      if (load)
        hold_par <= par_err_acc;
    end
  end

  assign rx_par_err = hold_par;
`else
  assign rx_par_err = 1'b0;
`endif

endmodule
